// File: rtl/phys_reg_free_list_ctrl.sv
// Circular free list of physical register tags with speculative (rename) and architectural (commit) heads.
// Optional FREE_LIST_STALL_CNT_EN adds a stall_cycles counter of cycles where rename was refused for lack of tags.
module phys_reg_free_list_ctrl #(
    parameter  int NO_PHY_REGS  = 64,
    parameter  int NO_ARCH_REGS = 32,
    parameter  int WAY          = 2,
    localparam int WIDTH        = $clog2(NO_PHY_REGS),
    localparam int FL_DEPTH     = NO_PHY_REGS - NO_ARCH_REGS,
    localparam int CW           = $clog2(FL_DEPTH + 1),
    localparam int PW           = $clog2(FL_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WAY-1:0]   alloc_req,
    output logic [WIDTH-1:0] alloc_pd [WAY],
    output logic             alloc_ok,
    output logic             free_list_empty,
    output logic [CW-1:0]    free_count,
    input  logic [WAY-1:0]   commit_alloc,
    input  logic [WAY-1:0]   commit_free_en,
    input  logic [WIDTH-1:0] commit_free_pd [WAY],
    input  logic             flush
`ifdef FREE_LIST_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    function automatic logic [CW-1:0] popcnt(input logic [WAY-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < WAY; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // Modular pointer advance; FL_DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [CW-1:0] inc);
        logic [CW:0] s;
        s = (CW+1)'(p) + (CW+1)'(inc);
        if (s >= (CW+1)'(FL_DEPTH)) begin
            s = s - (CW+1)'(FL_DEPTH);
        end
        return s[PW-1:0];
    endfunction

    logic [WIDTH-1:0] fl_q [FL_DEPTH];
    logic [WIDTH-1:0] fl_d [FL_DEPTH];
    logic [PW-1:0]    spec_head_q, spec_head_d;
    logic [PW-1:0]    arch_head_q, arch_head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    spec_count_q, spec_count_d;
    logic [CW-1:0]    arch_count_q, arch_count_d;

    logic [CW-1:0]    n_req;
    logic [CW-1:0]    n_free;
    logic [CW-1:0]    n_commit;
    logic [CW-1:0]    rd_offs;
    logic [CW-1:0]    wr_offs;

    assign free_count      = spec_count_q;
    assign free_list_empty = (spec_count_q == '0);

    // Grant is all-or-nothing; each requesting lane takes the next tag after lower requesting lanes.
    always_comb begin
        n_req    = popcnt(alloc_req);
        alloc_ok = !flush && (n_req <= spec_count_q);
        rd_offs  = '0;
        for (int k = 0; k < WAY; k++) begin
            alloc_pd[k] = '0;
            if (alloc_req[k] && !rst) begin
                alloc_pd[k] = fl_q[ptr_add(spec_head_q, rd_offs)];
            end
            if (alloc_req[k]) begin
                rd_offs = rd_offs + CW'(1);
            end
        end
        if (rst) begin
            alloc_ok = (n_req == '0);
        end
    end

    always_comb begin
        n_free   = popcnt(commit_free_en);
        n_commit = popcnt(commit_alloc);
        fl_d     = fl_q;
        wr_offs  = '0;
        for (int j = 0; j < WAY; j++) begin
            if (commit_free_en[j]) begin
                fl_d[ptr_add(tail_q, wr_offs)] = commit_free_pd[j];
                wr_offs = wr_offs + CW'(1);
            end
        end
        tail_d       = ptr_add(tail_q, n_free);
        arch_head_d  = ptr_add(arch_head_q, n_commit);
        arch_count_d = arch_count_q - n_commit + n_free;
        // Recovery sees this cycle's commits and frees before the copy.
        if (flush) begin
            spec_head_d  = arch_head_d;
            spec_count_d = arch_count_d;
        end else if (alloc_ok) begin
            spec_head_d  = ptr_add(spec_head_q, n_req);
            spec_count_d = spec_count_q - n_req + n_free;
        end else begin
            spec_head_d  = spec_head_q;
            spec_count_d = spec_count_q + n_free;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                fl_q[i] <= WIDTH'(NO_ARCH_REGS + i);
            end
            spec_head_q  <= '0;
            arch_head_q  <= '0;
            tail_q       <= '0;
            spec_count_q <= CW'(FL_DEPTH);
            arch_count_q <= CW'(FL_DEPTH);
        end else begin
            fl_q         <= fl_d;
            spec_head_q  <= spec_head_d;
            arch_head_q  <= arch_head_d;
            tail_q       <= tail_d;
            spec_count_q <= spec_count_d;
            arch_count_q <= arch_count_d;
        end
    end

`ifdef FREE_LIST_STALL_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if ((n_req != '0) && !alloc_ok && !flush) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        ((CW+2)'(arch_count_q) + (CW+2)'(n_free)) <= ((CW+2)'(FL_DEPTH) + (CW+2)'(n_commit)));

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        ((CW+2)'(arch_count_q) + (CW+2)'(n_free)) >= (CW+2)'(n_commit));

    for (genvar g = 0; g < WAY; g++) begin : g_p0_chk
        a_no_p0_free: assert property (@(posedge clk) disable iff (rst)
            commit_free_en[g] |-> (commit_free_pd[g] != '0));
    end
`endif

endmodule

// File: tb/tb_phys_reg_free_list_ctrl.sv
// Bench for phys_reg_free_list_ctrl: constant vector table, hand sequences, and randomized traffic
// against a queue-based model of the speculative and architectural free lists.
module tb_phys_reg_free_list_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] alloc_req;
    logic [5:0] alloc_pd [2];
    logic       alloc_ok;
    logic       free_list_empty;
    logic [5:0] free_count;
    logic [1:0] commit_alloc;
    logic [1:0] commit_free_en;
    logic [5:0] commit_free_pd [2];
    logic       flush;
    logic [31:0] stall_cycles;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [5:0] spec_q [$];
    logic [5:0] arch_q [$];

    typedef struct {
        logic [1:0] req;
        logic [1:0] ca;
        logic [1:0] fen;
        logic [5:0] fpd0;
        logic [5:0] fpd1;
        logic       fl;
        logic       e_ok;
        logic [5:0] e_pd0;
        logic [5:0] e_pd1;
        logic [5:0] e_cnt;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    phys_reg_free_list_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_req       (alloc_req),
        .alloc_pd        (alloc_pd),
        .alloc_ok        (alloc_ok),
        .free_list_empty (free_list_empty),
        .free_count      (free_count),
        .commit_alloc    (commit_alloc),
        .commit_free_en  (commit_free_en),
        .commit_free_pd  (commit_free_pd),
`ifdef FREE_LIST_STALL_CNT_EN
        .stall_cycles    (stall_cycles),
`endif
        .flush           (flush)
    );

`ifndef FREE_LIST_STALL_CNT_EN
    assign stall_cycles = '0;
`endif

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic e_ok, input logic [5:0] e_pd0,
                               input logic [5:0] e_pd1, input logic [5:0] e_cnt, input bit chk_pd);
        checkVal({name, ".alloc_ok"}, 32'(alloc_ok), 32'(e_ok));
        checkVal({name, ".free_count"}, 32'(free_count), 32'(e_cnt));
        checkVal({name, ".empty"}, 32'(free_list_empty), 32'(e_cnt == 6'd0));
        if (chk_pd) begin
            checkVal({name, ".pd0"}, 32'(alloc_pd[0]), 32'(e_pd0));
            checkVal({name, ".pd1"}, 32'(alloc_pd[1]), 32'(e_pd1));
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [1:0] req, input logic [1:0] ca,
                                 input logic [1:0] fen, input logic [5:0] pd0, input logic [5:0] pd1,
                                 input logic fl);
        rst               = r;
        alloc_req         = req;
        commit_alloc      = ca;
        commit_free_en    = fen;
        commit_free_pd[0] = pd0;
        commit_free_pd[1] = pd1;
        flush             = fl;
    endtask

    // Model: spec_q holds allocatable tags in hand-out order, arch_q the committed-state list.
    task automatic modelStep();
        int  n;
        bit  ok;
        if (rst) begin
            spec_q.delete();
            arch_q.delete();
            for (int i = 0; i < 32; i++) begin
                spec_q.push_back(6'(32 + i));
                arch_q.push_back(6'(32 + i));
            end
            return;
        end
        n  = int'(alloc_req[0]) + int'(alloc_req[1]);
        ok = !flush && (n <= spec_q.size());
        if (ok) begin
            for (int i = 0; i < n; i++) void'(spec_q.pop_front());
        end
        for (int l = 0; l < 2; l++) begin
            if (commit_alloc[l] && arch_q.size() > 0) void'(arch_q.pop_front());
        end
        for (int l = 0; l < 2; l++) begin
            if (commit_free_en[l]) begin
                spec_q.push_back(commit_free_pd[l]);
                arch_q.push_back(commit_free_pd[l]);
            end
        end
        if (flush) spec_q = arch_q;
    endtask

    task automatic modelExpect(output logic e_ok, output logic [5:0] e_pd0, output logic [5:0] e_pd1,
                               output logic [5:0] e_cnt);
        int n;
        n     = int'(alloc_req[0]) + int'(alloc_req[1]);
        e_ok  = !flush && (n <= spec_q.size());
        e_cnt = 6'(spec_q.size());
        e_pd0 = '0;
        e_pd1 = '0;
        if (e_ok && alloc_req[0]) e_pd0 = spec_q[0];
        if (e_ok && alloc_req[1]) e_pd1 = spec_q[alloc_req[0] ? 1 : 0];
    endtask

    task automatic runCycle(input string name, input bit use_model, input logic e_ok,
                            input logic [5:0] e_pd0, input logic [5:0] e_pd1, input logic [5:0] e_cnt,
                            input bit chk_pd);
        logic       m_ok;
        logic [5:0] m_pd0, m_pd1, m_cnt;
        @(negedge clk);
        if (use_model) begin
            modelExpect(m_ok, m_pd0, m_pd1, m_cnt);
            checkOutput(name, m_ok, m_pd0, m_pd1, m_cnt, m_ok);
        end else begin
            checkOutput(name, e_ok, e_pd0, e_pd1, e_cnt, chk_pd);
        end
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        @(negedge clk);
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        idleCycle();
        runCycle("reset", 1'b0, 1'b0, 6'd0, 6'd0, 6'd32, 1'b1);
        applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    endtask

    function automatic bit inArch(input logic [5:0] t);
        foreach (arch_q[i]) if (arch_q[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic randomPhase(input int cycles, input int pfree);
        logic [1:0] req, ca, fen;
        logic [5:0] pd [2];
        logic [5:0] cand;
        int         infl, room, a;
        bit         found;
        for (int c = 0; c < cycles; c++) begin
            req  = 2'($urandom_range(0, 3));
            infl = arch_q.size() - spec_q.size();
            ca   = '0;
            for (int l = 0; l < 2; l++) begin
                if ($urandom_range(0, 1) == 1 && infl > 0) begin
                    ca[l] = 1'b1;
                    infl--;
                end
            end
            a    = int'(ca[0]) + int'(ca[1]);
            room = 32 - arch_q.size() + a;
            fen  = '0;
            pd[0] = '0;
            pd[1] = '0;
            for (int l = 0; l < 2; l++) begin
                if (int'($urandom_range(0, 99)) < pfree && room > 0) begin
                    found = 1'b0;
                    cand  = '0;
                    for (int t = 0; t < 200 && !found; t++) begin
                        cand = 6'($urandom_range(1, 63));
                        if (!inArch(cand) && !(l == 1 && fen[0] && cand == pd[0])) found = 1'b1;
                    end
                    if (found) begin
                        fen[l] = 1'b1;
                        pd[l]  = cand;
                        room--;
                    end
                end
            end
            applyStimulus(1'b0, req, ca, fen, pd[0], pd[1], ($urandom_range(0, 11) == 0));
            runCycle("rand", 1'b1, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
        end
    endtask

    initial begin
        //        req    ca     fen    pd0   pd1   fl    ok    pd0    pd1    cnt
        vecs[0] = '{2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b1, 6'd32, 6'd33, 6'd32};
        vecs[1] = '{2'b10, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b1, 6'd0,  6'd34, 6'd30};
        vecs[2] = '{2'b01, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b1, 6'd35, 6'd0,  6'd29};
        vecs[3] = '{2'b00, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 1'b1, 6'd0,  6'd0,  6'd28};
        vecs[4] = '{2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 1'b1, 1'b0, 6'd0,  6'd0,  6'd28};
        vecs[5] = '{2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b1, 6'd34, 6'd35, 6'd30};
        vecs[6] = '{2'b00, 2'b00, 2'b01, 6'd5, 6'd0, 1'b0, 1'b1, 6'd0,  6'd0,  6'd28};
        vecs[7] = '{2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b1, 6'd0,  6'd0,  6'd29};
        vecs[8] = '{2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b1, 6'd36, 6'd37, 6'd29};

        applyStimulus(1'b1, 2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        @(posedge clk);
        #1;
        doReset();

        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, vecs[i].req, vecs[i].ca, vecs[i].fen, vecs[i].fpd0, vecs[i].fpd1, vecs[i].fl);
            runCycle($sformatf("vec%0d", i), 1'b0, vecs[i].e_ok, vecs[i].e_pd0, vecs[i].e_pd1,
                     vecs[i].e_cnt, vecs[i].e_ok);
        end

        // Drain to one tag, stall with a same-cycle free, then retry and empty the list.
        doReset();
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, 2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
            runCycle("drain", 1'b0, 1'b1, 6'(32 + 2 * i), 6'(33 + 2 * i), 6'(32 - 2 * i), 1'b1);
        end
        applyStimulus(1'b0, 2'b01, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        runCycle("drain_last", 1'b0, 1'b1, 6'd62, 6'd0, 6'd2, 1'b1);
        applyStimulus(1'b0, 2'b11, 2'b01, 2'b01, 6'd5, 6'd0, 1'b0);
        runCycle("stall", 1'b0, 1'b0, 6'd0, 6'd0, 6'd1, 1'b0);
        applyStimulus(1'b0, 2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        runCycle("retry", 1'b0, 1'b1, 6'd63, 6'd5, 6'd2, 1'b1);
        applyStimulus(1'b0, 2'b01, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        runCycle("empty_req", 1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
        applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        runCycle("empty_noreq", 1'b0, 1'b1, 6'd0, 6'd0, 6'd0, 1'b1);

        // Flush in the same cycle as a commit and a free.
        doReset();
        applyStimulus(1'b0, 2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        runCycle("fc_a0", 1'b0, 1'b1, 6'd32, 6'd33, 6'd32, 1'b1);
        applyStimulus(1'b0, 2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        runCycle("fc_a1", 1'b0, 1'b1, 6'd34, 6'd35, 6'd30, 1'b1);
        applyStimulus(1'b0, 2'b00, 2'b01, 2'b01, 6'd7, 6'd0, 1'b1);
        runCycle("fc_flush", 1'b0, 1'b0, 6'd0, 6'd0, 6'd28, 1'b0);
        applyStimulus(1'b0, 2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        runCycle("fc_after", 1'b0, 1'b1, 6'd33, 6'd34, 6'd32, 1'b1);

        // Reset in the middle of traffic with requests pending.
        applyStimulus(1'b0, 2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        runCycle("pre_rst", 1'b0, 1'b1, 6'd35, 6'd36, 6'd30, 1'b1);
        doReset();
        applyStimulus(1'b0, 2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        runCycle("post_rst", 1'b0, 1'b1, 6'd32, 6'd33, 6'd32, 1'b1);

        randomPhase(300, 20);
        randomPhase(300, 70);
        randomPhase(200, 40);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] time limit expired");
    end

endmodule
